// File: rtl/regfile_reader.sv
`default_nettype none
// ============================================================================
// Module   : regfile_reader
// Purpose  : On a start request, snapshots the four registers of an external
//            dual-read-port register file (two registers per cycle) and then
//            streams them out as bytes over a valid/ready handshake, followed
//            by a one-cycle done pulse.
// Optional : define REGFILE_READER_CHECKSUM_EN to append a fifth byte equal to
//            the XOR of the four snapshotted registers.
// Ports    : clk        - single clock, all state changes on posedge
//            rst        - synchronous, active-low reset
//            start      - one-cycle request, honoured only while idle
//            rd_addr_a  - read port A address (registered)
//            rd_addr_b  - read port B address (registered)
//            rd_data_a  - read port A data (combinational from rd_addr_a)
//            rd_data_b  - read port B data (combinational from rd_addr_b)
//            out_data   - streamed byte
//            out_valid  - out_data is valid
//            out_ready  - downstream accepts out_data
//            busy       - high in every state except idle
//            done       - one-cycle pulse after the final byte transfers
// Revision : 1.0 - initial release
// ============================================================================
module regfile_reader #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [1:0]        rd_addr_a,
    output logic [1:0]        rd_addr_b,
    input  logic [DATA_W-1:0] rd_data_a,
    input  logic [DATA_W-1:0] rd_data_b,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ0 = 3'd1,
        S_READ1 = 3'd2,
        S_SEND  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

`ifdef REGFILE_READER_CHECKSUM_EN
    localparam logic [2:0] c_LAST_IDX = 3'd4;
`else
    localparam logic [2:0] c_LAST_IDX = 3'd3;
`endif

    state_t              r_state;
    logic [2:0]          r_idx;
    logic [DATA_W-1:0]   r_buf [4];
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_valid;
    logic                r_busy;
    logic                r_done;
    logic [1:0]          r_rd_addr_a;
    logic [1:0]          r_rd_addr_b;

    logic [1:0]          w_idx_inc;
    logic [DATA_W-1:0]   w_next_byte;

    // Byte to present after the current one is accepted. Only meaningful
    // when the current index is not the last one.
    assign w_idx_inc = r_idx[1:0] + 2'd1;

    always_comb begin
        w_next_byte = r_buf[w_idx_inc];
`ifdef REGFILE_READER_CHECKSUM_EN
        if (r_idx[1:0] == 2'd3) begin
            w_next_byte = r_buf[0] ^ r_buf[1] ^ r_buf[2] ^ r_buf[3];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_idx       <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                r_buf[i] <= '0;
            end
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rd_addr_a <= 2'd0;
            r_rd_addr_b <= 2'd1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_READ0;
                        r_busy  <= 1'b1;
                    end
                end
                S_READ0: begin
                    // Read data is sampled on this edge, so a write landing
                    // on the same edge is not seen (pre-write snapshot).
                    r_buf[0]    <= rd_data_a;
                    r_buf[1]    <= rd_data_b;
                    r_rd_addr_a <= 2'd2;
                    r_rd_addr_b <= 2'd3;
                    r_state     <= S_READ1;
                end
                S_READ1: begin
                    r_buf[2]    <= rd_data_a;
                    r_buf[3]    <= rd_data_b;
                    r_idx       <= 3'd0;
                    // buf[0] was captured one edge earlier, so it can be
                    // presented immediately on entry to SEND.
                    r_out_data  <= r_buf[0];
                    r_out_valid <= 1'b1;
                    r_rd_addr_a <= 2'd0;
                    r_rd_addr_b <= 2'd1;
                    r_state     <= S_SEND;
                end
                S_SEND: begin
                    if (out_ready) begin
                        if (r_idx == c_LAST_IDX) begin
                            r_out_valid <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_idx      <= r_idx + 3'd1;
                            r_out_data <= w_next_byte;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rd_addr_a = r_rd_addr_a;
    assign rd_addr_b = r_rd_addr_b;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_regfile_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_reader
// Purpose  : Self-checking bench for regfile_reader. Holds a small register
//            file model and a per-transaction list of expected bytes derived
//            from the register contents at the time of the request.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_reader;

`ifdef REGFILE_READER_CHECKSUM_EN
    localparam int c_NBYTES = 5;
`else
    localparam int c_NBYTES = 4;
`endif

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] rd_addr_a;
    logic [1:0] rd_addr_b;
    logic [7:0] rd_data_a;
    logic [7:0] rd_data_b;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;

    // Register file with one write port; writes land on posedge
    logic       we;
    logic [1:0] wa;
    logic [7:0] wd;
    logic [7:0] rf [4];
    logic [7:0] m_rf [4];

    int n_cmp;
    int n_err;

    regfile_reader #(.DATA_W(8)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (we) rf[wa] <= wd;
    end
    assign rd_data_a = rf[rd_addr_a];
    assign rd_data_b = rf[rd_addr_b];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_regs(input logic [7:0] v0, input logic [7:0] v1,
                             input logic [7:0] v2, input logic [7:0] v3);
        logic [7:0] v [4];
        v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            we = 1'b1; wa = 2'(i); wd = v[i];
            m_rf[i] = v[i];
        end
        @(negedge clk);
        we = 1'b0;
    endtask

    // mode: 0 = ready always high, 1 = ready high every third cycle,
    //       2 = random ready.
    // hold: number of cycles start stays high (counted from the request cycle).
    // wr2 : write 0xAA to R2 on the edge that captures R2/R3.
    // abort_after: if >0, reset once this many bytes have been accepted.
    task automatic run_txn(input int mode, input int hold, input bit wr2, input int abort_after);
        logic [7:0] q [5];
        int  sent;
        int  done_n;
        int  n;
        bit  rdy;
        bit  exp_valid;
        for (int i = 0; i < 4; i++) q[i] = m_rf[i];
        q[4] = m_rf[0] ^ m_rf[1] ^ m_rf[2] ^ m_rf[3];
        sent   = 0;
        done_n = -1;
        @(negedge clk);
        start = 1'b1;
        for (n = 1; n <= 200; n++) begin
            @(negedge clk);
            start = (n < hold);
            we = wr2 && (n == 2);
            wa = 2'd2;
            wd = 8'hAA;
            if (abort_after > 0 && sent == abort_after) begin
                rst = 1'b0;
                @(negedge clk);
                rst   = 1'b1;
                start = 1'b0;
                chk("abort_valid", 32'(out_valid), 32'd0);
                chk("abort_busy",  32'(busy),      32'd0);
                chk("abort_done",  32'(done),      32'd0);
                chk("abort_addr",  {rd_addr_a, rd_addr_b}, 32'h1);
                return;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (n % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            exp_valid = (n >= 3) && (sent < c_NBYTES);
            chk("valid", 32'(out_valid), 32'(exp_valid));
            if (exp_valid) chk("data", 32'(out_data), 32'(q[sent]));
            chk("done", 32'(done), 32'(n == done_n));
            chk("busy", 32'(busy), 32'(done_n < 0 || n <= done_n));
            if (n == 1) chk("addr_r0", {rd_addr_a, rd_addr_b}, 32'h1);
            if (n == 2) chk("addr_r1", {rd_addr_a, rd_addr_b}, 32'hB);
            if (exp_valid && rdy) begin
                sent++;
                if (sent == c_NBYTES) done_n = n + 1;
            end
            if (done_n > 0 && n == done_n + 1) break;
        end
        chk("count", 32'(sent), 32'(c_NBYTES));
        start     = 1'b0;
        we        = 1'b0;
        out_ready = 1'b0;
        if (wr2) m_rf[2] = 8'hAA;
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1'b0; start = 1'b0; out_ready = 1'b0;
        we = 1'b0; wa = 2'd0; wd = 8'd0;
        for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_done",  32'(done),      32'd0);
        chk("rst_data",  32'(out_data),  32'd0);
        chk("rst_addr",  {rd_addr_a, rd_addr_b}, 32'h1);
        rst = 1'b1;

        // Basic stream, full throughput
        load_regs(8'h11, 8'h22, 8'h33, 8'h44);
        run_txn(0, 1, 1'b0, 0);
        // Back-pressure pattern
        run_txn(1, 1, 1'b0, 0);
        // Write to R2 on its capture edge: old value must be streamed
        run_txn(0, 1, 1'b1, 0);
        // Long start: exactly one stream
        load_regs(8'h11, 8'h22, 8'h33, 8'h44);
        run_txn(1, 10, 1'b0, 0);
        // Reset after two bytes, then a fresh full stream
        run_txn(0, 1, 1'b0, 2);
        run_txn(0, 1, 1'b0, 0);
        // All ones
        load_regs(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        run_txn(0, 1, 1'b0, 0);
        // Random contents and random back-pressure
        for (int t = 0; t < 8; t++) begin
            load_regs(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            run_txn(2, 1, 1'($urandom_range(0, 1)), 0);
        end

        repeat (2) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_reader.md
REGFILE_READER -- requirements
Module: regfile_reader

Interface
REQ-001 Parameter: DATA_W, default 8, register and output byte width.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous, active-low reset; rst=0 at posedge clk resets the block.
REQ-004 start  input  1  one-cycle request to snapshot and stream all four registers.
REQ-005 rd_addr_a  output  2  register-file read port A address.
REQ-006 rd_addr_b  output  2  register-file read port B address.
REQ-007 rd_data_a  input  DATA_W  read port A data, combinational from rd_addr_a.
REQ-008 rd_data_b  input  DATA_W  read port B data, combinational from rd_addr_b.
REQ-009 out_data  output  DATA_W  streamed byte.
REQ-010 out_valid  output  1  out_data is valid.
REQ-011 out_ready  input  1  downstream accepts out_data when high with out_valid.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse after the final byte transfers.

Function
REQ-014 FSM states: IDLE, READ0, READ1, SEND, DONE.
REQ-015 IDLE: rd_addr_a=0, rd_addr_b=1; start=1 -> READ0 next cycle; otherwise stay in IDLE.
REQ-016 READ0: drive rd_addr_a=0, rd_addr_b=1; capture rd_data_a into buf[0] and rd_data_b into buf[1] at the clock edge; go to READ1.
REQ-017 READ1: drive rd_addr_a=2, rd_addr_b=3; capture into buf[2] and buf[3]; clear byte index; go to SEND.
REQ-018 Snapshot: a register-file write landing on the capture edge is not reflected in the captured value; the captured value is the pre-write content.
REQ-019 SEND: out_valid=1 and out_data=buf[idx]; on out_valid and out_ready at a clock edge, idx increments.
REQ-020 Stream order: buf[0], buf[1], buf[2], buf[3] (then the checksum byte if REQ-030 applies).
REQ-021 While out_valid=1 and out_ready=0, out_data and idx stay stable for any number of cycles.
REQ-022 When the last byte transfers, go to DONE; out_valid deasserts in the next cycle with no gap byte.
REQ-023 DONE: done=1 for exactly one cycle, then IDLE.
REQ-024 start is ignored whenever busy=1; it is neither queued nor restarted.
REQ-025 start asserted in the same cycle that DONE returns to IDLE is ignored; the first accepted start is the first cycle with state IDLE.
REQ-026 The byte index wraps never: the transfer count is exactly 4 (or 5) per start.
REQ-027 Transfer latency: first out_valid is the 3rd cycle after the start edge (IDLE->READ0->READ1->SEND).

Reset
REQ-028 rst=0: state=IDLE, idx=0, buf cleared to 0, out_valid=0, out_data=0, busy=0, done=0, rd_addr_a=0, rd_addr_b=1.
REQ-029 Reset mid-operation (any state) aborts immediately; no done pulse; the next start begins a fresh snapshot.

Configuration
REQ-030 Macro REGFILE_READER_CHECKSUM_EN defined: after buf[3], a fifth byte equal to buf[0]^buf[1]^buf[2]^buf[3] is sent under the same handshake, and done follows its transfer.
REQ-031 Macro not defined: exactly four bytes are sent and no checksum logic is present.

Verification
REQ-032 Registers {0x11,0x22,0x33,0x44}, out_ready=1, one start pulse -> out_data 0x11,0x22,0x33,0x44 on consecutive cycles starting at start+3, then a done pulse; with CHECKSUM_EN, 0x44 is followed by 0x44 (the XOR) and then done.
REQ-033 Same registers, out_ready toggling 1,0,0,1,... -> each byte is held stable while out_ready=0, there is no duplication or loss, and the same sequence is delivered.
REQ-034 Register-file write of R2=0xAA on the READ1 capture edge -> the stream carries the old R2 value 0x33.
REQ-035 start held high for 10 cycles -> exactly one 4-byte (or 5-byte) stream and one done pulse; busy stays high throughout.
REQ-036 rst=0 during SEND after 2 bytes -> the next cycle shows out_valid=0, busy=0, done=0; a new start streams all bytes starting from buf[0].
REQ-037 Registers all 0xFF, out_ready=1 -> 0xFF x4 is streamed; with CHECKSUM_EN the checksum byte is 0x00.
